// File: rtl/gps_gate_sequencer_pkg.sv
// Shared definitions for the GPS gate sequencer: FSM state encoding and default sizing.
package gps_gate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2
  } state_t;

  localparam int DEFAULT_COUNTER_WIDTH  = 35;
  localparam int DEFAULT_WINDOW_BITS    = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 20_000_000;

endpackage

// File: rtl/gps_gate_sequencer_gate_counter.sv
// Saturating gate cycle counter: clear to 0, load to 1, or increment; ovf marks an attempted
// increment past all-ones since the last clear/load.
module gate_counter #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      cnt <= WIDTH'(1);
      ovf <= 1'b0;
    end else if (inc) begin
      if (&cnt) ovf <= 1'b1;
      else      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/gps_gate_sequencer.sv
// GPS 1PPS gate sequencer: measures reference-clock cycles over window_len+1 PPS intervals.
// Optional macro GPS_PULSE_FILTER_EN qualifies PPS edges with a 4-cycle high-level filter.
module gps_gate_sequencer
  import gps_gate_pkg::*;
#(
  parameter int COUNTER_WIDTH  = DEFAULT_COUNTER_WIDTH,
  parameter int WINDOW_BITS    = DEFAULT_WINDOW_BITS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     system_clk,
  input  logic                     rst_n,
  input  logic                     gps_pulse,
  input  logic                     enable,
  input  logic [WINDOW_BITS-1:0]   window_len,
  input  logic                     result_ack,
  output logic [COUNTER_WIDTH-1:0] result,
  output logic                     result_overflow,
  output logic                     result_valid,
  output logic                     result_overrun,
  output logic                     gps_lost,
  output logic [1:0]               state
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                   state_q, state_d;
  logic                     s1, s2, s3;
  logic                     pps_edge;
  logic                     open_gate, close_gate, abort, clear_all;
  logic [WINDOW_BITS-1:0]   pulses, win;
  logic [TMO_W-1:0]         tmo;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic                     ovf;

  // PPS synchroniser and rising-edge strobe
  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= gps_pulse;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef GPS_PULSE_FILTER_EN
  logic s4, s5, s6;

  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      s4 <= 1'b0;
      s5 <= 1'b0;
      s6 <= 1'b0;
    end else begin
      s4 <= s3;
      s5 <= s4;
      s6 <= s5;
    end
  end

  // Fires once, three cycles after the plain edge, only if s2 held high for four cycles.
  assign pps_edge = s2 & s3 & s4 & s5 & ~s6;
`else
  assign pps_edge = s2 & ~s3;
`endif

  always_ff @(posedge system_clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // enable low overrides everything, including a coincident PPS edge.
  always_comb begin
    state_d    = state_q;
    open_gate  = 1'b0;
    close_gate = 1'b0;
    abort      = 1'b0;
    clear_all  = 1'b0;
    if (!enable) begin
      state_d   = ST_IDLE;
      clear_all = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (pps_edge) begin
            state_d   = ST_GATE;
            open_gate = 1'b1;
          end
        end
        ST_GATE: begin
          if (pps_edge) begin
            close_gate = (pulses == win);
          end else if (tmo == TMO_LAST) begin
            abort   = 1'b1;
            state_d = ST_ARM;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state = state_q;

  gate_counter #(
    .WIDTH (COUNTER_WIDTH)
  ) u_gate_counter (
    .clk   (system_clk),
    .rst_n (rst_n),
    .clear (clear_all | abort),
    .load  (open_gate | close_gate),
    .inc   (state_q == ST_GATE),
    .cnt   (cnt),
    .ovf   (ovf)
  );

  // Handshake: result_valid rises on every gate close and stays high until a one-cycle
  // result_ack; an ack while result_valid is low has no effect. A close that lands on a
  // still-valid, un-acked result overwrites it and sets the sticky result_overrun.
  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      pulses          <= '0;
      win             <= '0;
      tmo             <= '0;
      gps_lost        <= 1'b0;
      result          <= '0;
      result_overflow <= 1'b0;
      result_valid    <= 1'b0;
      result_overrun  <= 1'b0;
    end else begin
      if (clear_all | abort | open_gate | pps_edge) tmo <= '0;
      else if (state_q == ST_GATE)                  tmo <= tmo + TMO_W'(1);

      if (clear_all | abort | open_gate | close_gate)  pulses <= '0;
      else if (state_q == ST_GATE && pps_edge)         pulses <= pulses + WINDOW_BITS'(1);

      if (open_gate | close_gate) win <= window_len;

      if (abort)          gps_lost <= 1'b1;
      else if (open_gate) gps_lost <= 1'b0;

      if (close_gate) begin
        result          <= cnt;
        result_overflow <= ovf;
        result_valid    <= 1'b1;
        if (result_valid && !result_ack) result_overrun <= 1'b1;
        else if (result_valid)           result_overrun <= 1'b0;
      end else if (result_ack && result_valid) begin
        result_valid   <= 1'b0;
        result_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gps_gate_sequencer.sv
// Testbench for gps_gate_sequencer: randomized PPS trains checked against a pulse-level model.
module tb_gps_gate_sequencer;

  localparam int TMO = 100;
`ifdef GPS_PULSE_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic        system_clk = 1'b0;
  logic        rst_n;
  logic        gps_pulse;
  logic        enable;
  logic [3:0]  window_len;
  logic        result_ack;
  logic [34:0] result;
  logic        result_overflow, result_valid, result_overrun, gps_lost;
  logic [1:0]  state;
  logic [5:0]  result_6;
  logic        result_overflow_6, result_valid_6, result_overrun_6, gps_lost_6;
  logic [1:0]  state_6;

  gps_gate_sequencer #(.COUNTER_WIDTH(35), .WINDOW_BITS(4), .TIMEOUT_CYCLES(TMO)) dut (
    .system_clk(system_clk), .rst_n(rst_n), .gps_pulse(gps_pulse), .enable(enable),
    .window_len(window_len), .result_ack(result_ack), .result(result),
    .result_overflow(result_overflow), .result_valid(result_valid),
    .result_overrun(result_overrun), .gps_lost(gps_lost), .state(state)
  );

  gps_gate_sequencer #(.COUNTER_WIDTH(6), .WINDOW_BITS(4), .TIMEOUT_CYCLES(TMO)) dut6 (
    .system_clk(system_clk), .rst_n(rst_n), .gps_pulse(gps_pulse), .enable(enable),
    .window_len(window_len), .result_ack(result_ack), .result(result_6),
    .result_overflow(result_overflow_6), .result_valid(result_valid_6),
    .result_overrun(result_overrun_6), .gps_lost(gps_lost_6), .state(state_6)
  );

  // Clock and reset
  always #5 system_clk = ~system_clk;

  int          checks = 0;
  int          errors = 0;
  logic [34:0] exp_q[$];
  logic [34:0] exp_v;

  // Pulse-level reference model: each gate spans win+1 PPS intervals.
  bit     m_in_gate;
  int     m_win, m_pulses;
  longint m_acc;

  task automatic model_reset();
    m_in_gate = 1'b0;
    m_pulses  = 0;
    m_acc     = 0;
    exp_q.delete();
  endtask

  task automatic model_rise(input int gap);
    if (!m_in_gate) begin
      m_in_gate = 1'b1;
      m_win     = int'(window_len);
      m_pulses  = 0;
      m_acc     = 0;
    end else begin
      m_acc += gap;
      if (m_pulses == m_win) begin
        exp_q.push_back(35'(m_acc));
        m_win    = int'(window_len);
        m_pulses = 0;
        m_acc    = 0;
      end else begin
        m_pulses++;
      end
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge system_clk);
    #1;
  endtask

  task automatic pulse_rise();
    gps_pulse = 1'b1;
    tick(8);
    gps_pulse = 1'b0;
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    tick(1);
    result_ack = 1'b0;
  endtask

  task automatic restart();
    enable     = 1'b0;
    result_ack = 1'b1;
    tick(2);
    result_ack = 1'b0;
    enable     = 1'b1;
    tick(3);
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; gps_pulse = 1'b0; result_ack = 1'b0; window_len = '0;
    tick(3);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (result !== 35'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    checks++; if (result_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", result_overrun); end
    checks++; if (gps_lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %b expected 0", gps_lost); end
    checks++; if (result_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", result_overflow); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    restart();
    window_len = 4'd0;
    for (int k = 0; k < 4; k++) begin
      model_rise(50);
      pulse_rise();
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL basic_state: got %0d expected 2", state); end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++; if (result !== exp_v) begin errors++; $display("FAIL basic_result: got %0d expected %0d", result, exp_v); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", result_valid); end
        checks++; if (result_overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", result_overflow); end
      end else begin
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_novalid: got %b expected 0", result_valid); end
      end
      do_ack();
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_ack: got %b expected 0", result_valid); end
      tick(50 - 9);
    end
  endtask

  task automatic test_window_fixed();
    restart();
    window_len = 4'd3;
    for (int k = 0; k < 10; k++) begin
      model_rise(20);
      pulse_rise();
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL win_state: got %0d expected 2", state); end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++; if (result !== exp_v || result_valid !== 1'b1) begin
          errors++; $display("FAIL win_result: got %0d valid %b expected %0d valid 1", result, result_valid, exp_v);
        end
      end else begin
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL win_novalid: got %b expected 0", result_valid); end
      end
      do_ack();
      if (k == 5) window_len = 4'd0;
      tick(20 - 9);
    end
  endtask

  task automatic test_window_random();
    int gap, gap_prev;
    restart();
    window_len = 4'($urandom_range(0, 3));
    gap_prev   = 0;
    for (int k = 0; k < 16; k++) begin
      gap = $urandom_range(15, 45);
      model_rise(gap_prev);
      pulse_rise();
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL rnd_state: got %0d expected 2", state); end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++; if (result !== exp_v || result_valid !== 1'b1) begin
          errors++; $display("FAIL rnd_result: got %0d valid %b expected %0d valid 1", result, result_valid, exp_v);
        end
      end else begin
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rnd_novalid: got %b expected 0", result_valid); end
      end
      do_ack();
      if ($urandom_range(0, 2) == 0) window_len = 4'($urandom_range(0, 3));
      tick(gap - 9);
      gap_prev = gap;
    end
  endtask

  task automatic test_overrun();
    restart();
    window_len = 4'd0;
    model_rise(0); pulse_rise(); tick(30 - 8);
    model_rise(30); pulse_rise();
    exp_v = exp_q.pop_front();
    checks++; if (result !== exp_v || result_valid !== 1'b1 || result_overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_first: got %0d v%b o%b expected %0d v1 o0", result, result_valid, result_overrun, exp_v);
    end
    tick(40 - 8);
    model_rise(40); pulse_rise();
    exp_v = exp_q[$];
    exp_q.delete();
    checks++; if (result !== exp_v) begin errors++; $display("FAIL ovr_latest: got %0d expected %0d", result, exp_v); end
    checks++; if (result_overrun !== 1'b1 || result_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got o%b v%b expected o1 v1", result_overrun, result_valid);
    end
    do_ack();
    checks++; if (result_overrun !== 1'b0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_ack: got o%b v%b expected o0 v0", result_overrun, result_valid);
    end
    tick(25 - 9);
    model_rise(25); pulse_rise();
    exp_v = exp_q.pop_front();
    checks++; if (result !== exp_v || result_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_third: got %0d v%b expected %0d v1", result, result_valid, exp_v);
    end
    tick(35 - 8);
    // ack lands on the same clock edge as the closing PPS strobe
    model_rise(35);
    gps_pulse = 1'b1;
    tick(LAT - 1);
    result_ack = 1'b1;
    tick(1);
    result_ack = 1'b0;
    tick(8 - LAT);
    gps_pulse = 1'b0;
    exp_v = exp_q.pop_front();
    checks++; if (result !== exp_v || result_valid !== 1'b1 || result_overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_ack_close: got %0d v%b o%b expected %0d v1 o0", result, result_valid, result_overrun, exp_v);
    end
    tick(20);
  endtask

  task automatic test_timeout();
    restart();
    window_len = 4'd0;
    model_rise(0); pulse_rise(); tick(40 - 8);
    model_rise(40); pulse_rise();
    exp_v = exp_q.pop_front();
    checks++; if (result !== exp_v) begin errors++; $display("FAIL tmo_pre: got %0d expected %0d", result, exp_v); end
    do_ack();
    tick(LAT + TMO - 1 - 9);
    checks++; if (state !== 2'd2 || gps_lost !== 1'b0) begin
      errors++; $display("FAIL tmo_before: got state %0d lost %b expected 2 0", state, gps_lost);
    end
    tick(1);
    checks++; if (state !== 2'd1 || gps_lost !== 1'b1) begin
      errors++; $display("FAIL tmo_abort: got state %0d lost %b expected 1 1", state, gps_lost);
    end
    checks++; if (result_valid !== 1'b0 || result !== exp_v) begin
      errors++; $display("FAIL tmo_discard: got %0d v%b expected %0d v0", result, result_valid, exp_v);
    end
    tick(20);
    model_reset();
    model_rise(0); pulse_rise();
    checks++; if (state !== 2'd2 || gps_lost !== 1'b0) begin
      errors++; $display("FAIL tmo_recover: got state %0d lost %b expected 2 0", state, gps_lost);
    end
    tick(25 - 8);
    model_rise(25); pulse_rise();
    exp_v = exp_q.pop_front();
    checks++; if (result !== exp_v || result_valid !== 1'b1) begin
      errors++; $display("FAIL tmo_after: got %0d v%b expected %0d v1", result, result_valid, exp_v);
    end
    do_ack();
  endtask

  task automatic test_overflow();
    int gaps[4];
    logic [5:0] exp6;
    logic       exp_ovf;
    gaps[0] = 100;
    gaps[1] = 30;
    gaps[2] = $urandom_range(65, 99);
    gaps[3] = $urandom_range(10, 62);
    restart();
    window_len = 4'd0;
    pulse_rise();
    do_ack();
    for (int k = 0; k < 4; k++) begin
      tick(gaps[k] - 9);
      pulse_rise();
      exp6    = (gaps[k] > 63) ? 6'd63 : 6'(gaps[k]);
      exp_ovf = (gaps[k] > 63);
      checks++; if (result_6 !== exp6 || result_overflow_6 !== exp_ovf) begin
        errors++; $display("FAIL ovf6: gap %0d got %0d ovf %b expected %0d ovf %b", gaps[k], result_6, result_overflow_6, exp6, exp_ovf);
      end
      checks++; if (result !== 35'(gaps[k]) || result_overflow !== 1'b0) begin
        errors++; $display("FAIL ovf35: got %0d ovf %b expected %0d ovf 0", result, result_overflow, gaps[k]);
      end
      do_ack();
    end
  endtask

  task automatic test_enable_drop();
    restart();
    window_len = 4'd0;
    pulse_rise(); tick(30 - 8);
    pulse_rise();
    do_ack();
    tick(10);
    enable = 1'b0;
    tick(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL en_idle: got %0d expected 0", state); end
    checks++; if (result !== 35'd30 || result_valid !== 1'b0) begin
      errors++; $display("FAIL en_keep: got %0d v%b expected 30 v0", result, result_valid);
    end
    enable = 1'b1;
    tick(3);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL en_arm: got %0d expected 1", state); end
    pulse_rise(); tick(22 - 8);
    pulse_rise();
    checks++; if (result !== 35'd22 || result_valid !== 1'b1) begin
      errors++; $display("FAIL en_fresh: got %0d v%b expected 22 v1", result, result_valid);
    end
  endtask

  task automatic test_reset_mid_gate();
    tick(10);
    rst_n = 1'b0;
    tick(1);
    checks++; if (state !== 2'd0 || result !== 35'd0 || result_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got state %0d result %0d v%b expected 0 0 0", state, result, result_valid);
    end
    rst_n = 1'b1;
    tick(3);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_rearm: got %0d expected 1", state); end
  endtask

  task automatic test_glitch();
    restart();
    gps_pulse = 1'b1;
    tick(2);
    gps_pulse = 1'b0;
    tick(10);
`ifdef GPS_PULSE_FILTER_EN
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL glitch_ignored: got %0d expected 1", state); end
    pulse_rise();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL glitch_real: got %0d expected 2", state); end
`else
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL short_pulse: got %0d expected 2", state); end
`endif
    tick(10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window_fixed();
    test_window_random();
    test_overrun();
    test_timeout();
    test_overflow();
    test_enable_drop();
    test_reset_mid_gate();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
